// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and defaults for the bit-serial subtractor
package sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  localparam int SUB_WIDTH = 4;

endpackage

// File: rtl/fullsubtractor.sv
// rtl/fullsubtractor.sv - single-bit full-subtractor cell
module fullsubtractor (
  input  logic X,
  input  logic Y,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  assign D  = X ^ Y ^ Bi;
  assign Bo = (~X & Y) | (~(X ^ Y) & Bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - bit-serial ripple-borrow subtractor, LSB first
module serial_ripple_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  sub_state_t       state, state_next;
  logic [WIDTH-1:0] xr, yr, d_r, d_next;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic             bout_r, zero_r, ovf_r;
  logic             cell_d, cell_bo;
  logic             last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  fullsubtractor u_cell (
    .X  (xr[cnt]),
    .Y  (yr[cnt]),
    .Bi (borrow),
    .D  (cell_d),
    .Bo (cell_bo)
  );

  // Result with the current bit merged in, so the flags can be taken on the final RUN edge.
  always_comb begin
    d_next      = d_r;
    d_next[cnt] = cell_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xr     <= '0;
      yr     <= '0;
      d_r    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      bout_r <= 1'b0;
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr     <= x;
            yr     <= y;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          d_r    <= d_next;
          borrow <= cell_bo;
          cnt    <= last ? '0 : cnt + CNT_W'(1);
          if (last) begin
            bout_r <= cell_bo;
            zero_r <= (d_next == '0);
            ovf_r  <= (xr[WIDTH-1] != yr[WIDTH-1]) && (cell_d != xr[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign d    = d_r;
  assign bout = bout_r;
  assign zero = zero_r;
  assign ovf  = ovf_r;

endmodule
